// File: rtl/rgmii_rx_pkg.sv
// rgmii_pkg: shared definitions for the RGMII receive path.
//   rx_state_t    - framing FSM states
//   PREAMBLE_BYTE - 0x55 preamble octet
//   SFD_BYTE      - 0xD5 start-of-frame delimiter
//   CNT_W         - width of the frame / error counters
package rgmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned CNT_W         = 16;

endpackage

// File: rtl/rgmii_rx_if.sv
// rgmii_rx_if: byte stream leaving the RGMII receiver (no backpressure).
//   tdata  - payload byte
//   tvalid - byte valid
//   tlast  - last byte of a frame
//   tuser  - frame error, qualified by tlast
// master drives the stream, slave observes it.
interface rgmii_rx_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);

endinterface

// File: rtl/rgmii_rx_iddr.sv
// iddr: input DDR cell, same-edge-pipelined alignment.
//   clk_i - sampling clock
//   d_i   - DDR input bus
//   q1_o  - value sampled on the rising edge
//   q2_o  - value sampled on the following falling edge
// Both outputs change together on the rising edge after the falling sample.
// VENDOR selects the I/O register placement hints for "xilinx", "altera"
// and "gowin"; any other value gives the plain fabric model.
// No reset: capture registers only follow the pins.
module iddr #(
    parameter string       VENDOR = "xilinx",
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q1_o,
    output logic [WIDTH-1:0] q2_o
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    generate
        if (VENDOR == "xilinx") begin : g_xilinx
            (* IOB = "TRUE" *) logic [WIDTH-1:0] r_rise;
            (* IOB = "TRUE" *) logic [WIDTH-1:0] r_fall;
            always_ff @(posedge clk_i) r_rise <= d_i;
            always_ff @(negedge clk_i) r_fall <= d_i;
            always_ff @(posedge clk_i) begin
                r_q1 <= r_rise;
                r_q2 <= r_fall;
            end
        end else if (VENDOR == "altera") begin : g_altera
            (* altera_attribute = "-name FAST_INPUT_REGISTER ON" *) logic [WIDTH-1:0] r_rise;
            (* altera_attribute = "-name FAST_INPUT_REGISTER ON" *) logic [WIDTH-1:0] r_fall;
            always_ff @(posedge clk_i) r_rise <= d_i;
            always_ff @(negedge clk_i) r_fall <= d_i;
            always_ff @(posedge clk_i) begin
                r_q1 <= r_rise;
                r_q2 <= r_fall;
            end
        end else if (VENDOR == "gowin") begin : g_gowin
            (* syn_useioff = 1 *) logic [WIDTH-1:0] r_rise;
            (* syn_useioff = 1 *) logic [WIDTH-1:0] r_fall;
            always_ff @(posedge clk_i) r_rise <= d_i;
            always_ff @(negedge clk_i) r_fall <= d_i;
            always_ff @(posedge clk_i) begin
                r_q1 <= r_rise;
                r_q2 <= r_fall;
            end
        end else begin : g_generic
            logic [WIDTH-1:0] r_rise;
            logic [WIDTH-1:0] r_fall;
            always_ff @(posedge clk_i) r_rise <= d_i;
            always_ff @(negedge clk_i) r_fall <= d_i;
            always_ff @(posedge clk_i) begin
                r_q1 <= r_rise;
                r_q2 <= r_fall;
            end
        end
    endgenerate

    assign q1_o = r_q1;
    assign q2_o = r_q2;

endmodule

// File: rtl/rgmii_rx.sv
// rgmii_rx: RGMII receiver, DDR nibbles to an AXI-Stream style byte stream.
//   clk_i           - RGMII receive clock (only clock)
//   rst_i           - synchronous active-high reset
//   rgmii_rxd_i     - DDR data, low nibble rising / high nibble falling
//   rgmii_rx_ctl_i  - DDR control, RX_DV rising / RX_DV^RX_ER falling
//   m_axis_tdata_o  - payload byte
//   m_axis_tvalid_o - byte valid (no tready)
//   m_axis_tlast_o  - last byte of frame
//   m_axis_tuser_o  - frame error, qualified by tlast
//   frame_cnt_o     - good frames delivered (wrapping)
//   err_cnt_o       - errored or dropped frames (wrapping)
// Preamble and SFD are stripped. Payload passes through a one-byte hold
// register so the byte at which RX_DV falls can be flagged as tlast.
module rgmii_rx
    import rgmii_pkg::*;
#(
    parameter string VENDOR = "xilinx"
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       rgmii_rxd_i,
    input  logic             rgmii_rx_ctl_i,
    output logic [7:0]       m_axis_tdata_o,
    output logic             m_axis_tvalid_o,
    output logic             m_axis_tlast_o,
    output logic             m_axis_tuser_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic [4:0] w_q1;
    logic [4:0] w_q2;
    logic [7:0] w_byte;
    logic       w_dv;
    logic       w_er;

    iddr #(.VENDOR(VENDOR), .WIDTH(5)) u_iddr (
        .clk_i (clk_i),
        .d_i   ({rgmii_rx_ctl_i, rgmii_rxd_i}),
        .q1_o  (w_q1),
        .q2_o  (w_q2)
    );

    assign w_byte = {w_q2[3:0], w_q1[3:0]};
    assign w_dv   = w_q1[4];
    assign w_er   = w_q1[4] ^ w_q2[4];

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic             r_first;      // first cycle after reset release
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic             r_err_flag;
    logic [7:0]       r_tdata;
    logic             r_tvalid;
    logic             r_tlast;
    logic             r_tuser;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic w_load;
    logic w_emit;
    logic w_last;
    logic w_good;
    logic w_bad;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_first <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // dv already high right after reset means we joined mid-frame
                if (w_dv) begin
                    if (r_first)                    w_state_nxt = ST_DROP;
                    else if (w_byte == PREAMBLE_BYTE) w_state_nxt = ST_PREAMBLE;
                    else if (w_byte == SFD_BYTE)      w_state_nxt = ST_PAYLOAD;
                    else                              w_state_nxt = ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!w_dv)                        w_state_nxt = ST_IDLE;
                else if (w_er)                    w_state_nxt = ST_DROP;
                else if (w_byte == SFD_BYTE)      w_state_nxt = ST_PAYLOAD;
                else if (w_byte != PREAMBLE_BYTE) w_state_nxt = ST_DROP;
            end
            ST_PAYLOAD: begin
                if (w_dv) begin
                    w_load = 1'b1;
                    w_emit = r_hold_full;
                end else begin
                    w_state_nxt = ST_IDLE;
                    if (r_hold_full) begin
                        w_emit = 1'b1;
                        w_last = 1'b1;
                        w_good = ~r_err_flag;
                        w_bad  = r_err_flag;
                    end else begin
                        w_bad  = 1'b1;           // SFD with no payload
                    end
                end
            end
            ST_DROP: begin
                if (!w_dv) begin
                    w_state_nxt = ST_IDLE;
                    w_bad       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_err_flag  <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_tdata  <= w_emit ? r_hold : '0;
            r_tvalid <= w_emit;
            r_tlast  <= w_last;
            r_tuser  <= w_last & r_err_flag;
            if (w_load) begin
                r_hold      <= w_byte;
                r_hold_full <= 1'b1;
                r_err_flag  <= r_err_flag | w_er;
            end else begin
                r_hold_full <= 1'b0;
                r_err_flag  <= 1'b0;
            end
            if (w_good) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            if (w_bad)  r_err_cnt   <= r_err_cnt + CNT_W'(1);
        end
    end

    assign m_axis_tdata_o  = r_tdata;
    assign m_axis_tvalid_o = r_tvalid;
    assign m_axis_tlast_o  = r_tlast;
    assign m_axis_tuser_o  = r_tuser;
    assign frame_cnt_o     = r_frame_cnt;
    assign err_cnt_o       = r_err_cnt;

endmodule
